// File: rtl/booth_pkg.sv
// Shared types and helpers for the round-robin Booth multiply scheduler.
// Contents:
//   state_t      scheduler FSM states (IDLE, RUN, DONE)
//   booth_op_t   radix-2 Booth operation selected by {Q0, Q-1}
//   DEF_WIDTH / DEF_NREQ   default operand width and requester count
//   booth_op()   decodes {Q0, Q-1} into a Booth operation
//   rr_next()    round-robin pick: first requester at or after last+1
package booth_pkg;

    localparam int DEF_WIDTH = 6;
    localparam int DEF_NREQ  = 4;
    // Request vectors are widened to this size before arbitration.
    localparam int MAX_NREQ  = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        NOP = 2'd0,
        ADD = 2'd1,
        SUB = 2'd2
    } booth_op_t;

    function automatic booth_op_t booth_op(input logic q0, input logic qm1);
        booth_op_t op;
        case ({q0, qm1})
            2'b01:   op = ADD;
            2'b10:   op = SUB;
            default: op = NOP;
        endcase
        return op;
    endfunction

    // Returns the first set bit of req_v scanning (last+1) mod n upward,
    // wrapping around; 0 when nothing is requested.
    function automatic int rr_next(input logic [MAX_NREQ-1:0] req_v,
                                   input int last, input int n);
        int   pick;
        int   idx;
        logic found;
        pick  = 0;
        found = 1'b0;
        for (int k = 1; k <= MAX_NREQ; k++) begin
            if ((k <= n) && !found) begin
                idx = (last + k) % n;
                if (req_v[idx[4:0]]) begin
                    pick  = idx;
                    found = 1'b1;
                end else begin
                    found = 1'b0;
                end
            end else begin
                found = found;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/booth_step_datapath.sv
// Radix-2 Booth add/subtract-shift datapath.
// A and M are WIDTH+1 bits so that M = -2^(WIDTH-1) can be subtracted
// without overflow.
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   load          capture M = sext(x), Q = y, A = 0, Q-1 = 0
//   step          perform one Booth iteration
//   x, y          multiplicand and multiplier (two's complement)
//   product_nxt   {A[WIDTH-1:0], Q} as it will be after the current step
module booth_step_datapath
    import booth_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic               step,
    input  logic [WIDTH-1:0]   x,
    input  logic [WIDTH-1:0]   y,
    output logic [2*WIDTH-1:0] product_nxt
);

    logic [WIDTH:0]   a_r;
    logic [WIDTH:0]   m_r;
    logic [WIDTH-1:0] q_r;
    logic             qm1_r;
    logic [WIDTH:0]   sum_s;
    logic [WIDTH:0]   a_nxt_s;
    logic [WIDTH-1:0] q_nxt_s;
    logic             qm1_nxt_s;
    booth_op_t        op_s;

    // One Booth iteration: add/subtract M, then arithmetic shift of {A,Q,Q-1}.
    always_comb begin
        op_s = booth_op(q_r[0], qm1_r);
        case (op_s)
            ADD:     sum_s = a_r + m_r;
            SUB:     sum_s = a_r - m_r;
            NOP:     sum_s = a_r;
            default: sum_s = a_r;
        endcase
        a_nxt_s     = {sum_s[WIDTH], sum_s[WIDTH:1]};
        q_nxt_s     = {sum_s[0], q_r[WIDTH-1:1]};
        qm1_nxt_s   = q_r[0];
        product_nxt = {a_nxt_s[WIDTH-1:0], q_nxt_s};
    end

    // Operand capture and iteration registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r   <= '0;
            m_r   <= '0;
            q_r   <= '0;
            qm1_r <= 1'b0;
        end else if (load) begin
            a_r   <= '0;
            m_r   <= {x[WIDTH-1], x};
            q_r   <= y;
            qm1_r <= 1'b0;
        end else if (step) begin
            a_r   <= a_nxt_s;
            q_r   <= q_nxt_s;
            qm1_r <= qm1_nxt_s;
        end else begin
            a_r   <= a_r;
            q_r   <= q_r;
            qm1_r <= qm1_r;
        end
    end

endmodule

// File: rtl/booth_mult_scheduler.sv
// Shares one sequential Booth multiplier among NREQ requesters.
// Round-robin arbitration in IDLE (gnt is a combinational one-cycle pulse),
// WIDTH iterations in RUN, result held in DONE until res_valid && res_ready.
// Optional build macro BOOTH_ZERO_BYPASS_EN: a zero operand at grant skips
// RUN and goes straight to DONE with a zero product.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   req[NREQ]           per-requester request (operands stable while high)
//   x_in, y_in          packed operands, requester i at [i*WIDTH +: WIDTH]
//   gnt[NREQ]           one-hot acceptance pulse (IDLE only)
//   res_valid/res_ready result handshake
//   res_id, res_z       owner index and signed 2*WIDTH-bit product
//   busy                high whenever the FSM is not IDLE
module booth_mult_scheduler
    import booth_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int NREQ  = DEF_NREQ,
    parameter int IDW   = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] x_in,
    input  logic [NREQ*WIDTH-1:0] y_in,
    output logic [NREQ-1:0]       gnt,
    output logic                  res_valid,
    output logic [IDW-1:0]        res_id,
    output logic [2*WIDTH-1:0]    res_z,
    input  logic                  res_ready,
    output logic                  busy
);

    localparam int CW = $clog2(WIDTH + 1);

    state_t                state_r;
    state_t                state_nxt_s;
    logic [CW-1:0]         cnt_r;
    logic [IDW-1:0]        last_r;
    logic [IDW-1:0]        sel_s;
    logic [IDW-1:0]        res_id_r;
    logic [2*WIDTH-1:0]    res_z_r;
    logic [2*WIDTH-1:0]    prod_nxt_s;
    logic                  res_valid_r;
    logic [NREQ-1:0]       gnt_s;
    logic                  load_s;
    logic                  step_s;
    logic                  zero_s;
    logic [WIDTH-1:0]      x_sel_s;
    logic [WIDTH-1:0]      y_sel_s;
    logic [MAX_NREQ-1:0]   req_ext_s;

    // Round-robin selection and operand mux for the candidate winner.
    always_comb begin
        req_ext_s = MAX_NREQ'(req);
        sel_s     = IDW'(rr_next(req_ext_s, int'(last_r), NREQ));
        x_sel_s   = x_in[int'(sel_s)*WIDTH +: WIDTH];
        y_sel_s   = y_in[int'(sel_s)*WIDTH +: WIDTH];
`ifdef BOOTH_ZERO_BYPASS_EN
        zero_s    = (x_sel_s == '0) || (y_sel_s == '0);
`else
        zero_s    = 1'b0;
`endif
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state, grant and datapath control. gnt is gated by rst_n so all
    // outputs read zero while reset is held, even with requests pending.
    always_comb begin
        state_nxt_s = state_r;
        gnt_s       = '0;
        load_s      = 1'b0;
        step_s      = 1'b0;
        case (state_r)
            IDLE: begin
                if ((|req) && rst_n) begin
                    gnt_s[sel_s] = 1'b1;
                    load_s       = 1'b1;
                    if (zero_s) begin
                        state_nxt_s = DONE;
                    end else begin
                        state_nxt_s = RUN;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            RUN: begin
                step_s = 1'b1;
                if (cnt_r == CW'(1)) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = RUN;
                end
            end
            DONE: begin
                if (res_ready) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = DONE;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Iteration counter, round-robin pointer and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r       <= '0;
            last_r      <= IDW'(NREQ - 1);
            res_id_r    <= '0;
            res_z_r     <= '0;
            res_valid_r <= 1'b0;
        end else begin
            res_valid_r <= (state_nxt_s == DONE);
            if (load_s) begin
                cnt_r    <= CW'(WIDTH);
                last_r   <= sel_s;
                res_id_r <= sel_s;
            end else if (step_s) begin
                cnt_r    <= cnt_r - CW'(1);
            end else begin
                cnt_r    <= cnt_r;
            end
            // Product is taken from the final iteration as it retires.
            if (load_s && (state_nxt_s == DONE)) begin
                res_z_r <= '0;
            end else if (step_s && (cnt_r == CW'(1))) begin
                res_z_r <= prod_nxt_s;
            end else begin
                res_z_r <= res_z_r;
            end
        end
    end

    booth_step_datapath #(
        .WIDTH (WIDTH)
    ) u_dp (
        .clk         (clk),
        .rst_n       (rst_n),
        .load        (load_s),
        .step        (step_s),
        .x           (x_sel_s),
        .y           (y_sel_s),
        .product_nxt (prod_nxt_s)
    );

    assign gnt       = gnt_s;
    assign res_valid = res_valid_r;
    assign res_id    = res_id_r;
    assign res_z     = res_z_r;
    assign busy      = (state_r != IDLE);

endmodule

// File: tb/tb_booth_mult_scheduler.sv
// Self-checking bench for booth_mult_scheduler (WIDTH=6, NREQ=4).
// A cycle-level behavioural model (plain multiplication, round-robin scan)
// checks every output on every falling edge; directed sequences add
// hand-computed literal expectations, followed by randomized traffic.
module tb_booth_mult_scheduler;

    localparam int WIDTH = 6;
    localparam int NREQ  = 4;
    localparam int IDW   = 2;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic [NREQ-1:0]       req = '0;
    logic [NREQ*WIDTH-1:0] x_in = '0;
    logic [NREQ*WIDTH-1:0] y_in = '0;
    logic                  res_ready = 1'b1;
    logic [NREQ-1:0]       gnt;
    logic                  res_valid;
    logic [IDW-1:0]        res_id;
    logic [2*WIDTH-1:0]    res_z;
    logic                  busy;

    int checks = 0;
    int failures = 0;

    int              m_mode = 0;      // 0 idle, 1 computing, 2 result offered
    int              m_left = 0;
    int              m_last = NREQ - 1;
    int              m_id = 0;
    logic [11:0]     m_prod = '0;
    logic [NREQ-1:0] mdl_gnt = '0;

    booth_mult_scheduler #(.WIDTH(WIDTH), .NREQ(NREQ), .IDW(IDW)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .x_in(x_in), .y_in(y_in),
        .gnt(gnt), .res_valid(res_valid), .res_id(res_id), .res_z(res_z),
        .res_ready(res_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model and per-cycle compare.
    initial begin
        logic [NREQ-1:0] eg;
        logic [5:0] xv, yv;
        int pick, idx, p;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                chk("rst_gnt", 32'(gnt), 32'd0);
                chk("rst_valid", 32'(res_valid), 32'd0);
                chk("rst_busy", 32'(busy), 32'd0);
                chk("rst_z", 32'(res_z), 32'd0);
                chk("rst_id", 32'(res_id), 32'd0);
                m_mode = 0;
                m_last = NREQ - 1;
                mdl_gnt = '0;
            end else begin
                eg = '0;
                pick = -1;
                if (m_mode == 0 && req != '0) begin
                    for (int k = 1; k <= NREQ; k++) begin
                        idx = (m_last + k) % NREQ;
                        if (pick < 0 && req[idx[1:0]]) pick = idx;
                    end
                    eg[pick[1:0]] = 1'b1;
                end
                chk("gnt", 32'(gnt), 32'(eg));
                chk("busy", 32'(busy), 32'(m_mode != 0));
                chk("res_valid", 32'(res_valid), 32'(m_mode == 2));
                if (m_mode == 2) begin
                    chk("res_id", 32'(res_id), 32'(m_id));
                    chk("res_z", 32'(res_z), 32'(m_prod));
                end
                if (m_mode == 0) begin
                    if (pick >= 0) begin
                        xv = x_in[pick*WIDTH +: WIDTH];
                        yv = y_in[pick*WIDTH +: WIDTH];
                        p = $signed(xv) * $signed(yv);
                        m_prod = p[11:0];
                        m_id = pick;
                        m_last = pick;
                        m_mode = 1;
                        m_left = WIDTH;
`ifdef BOOTH_ZERO_BYPASS_EN
                        if (xv == 6'd0 || yv == 6'd0) m_mode = 2;
`endif
                    end
                end else if (m_mode == 1) begin
                    m_left--;
                    if (m_left == 0) m_mode = 2;
                end else begin
                    if (res_ready) m_mode = 0;
                end
                mdl_gnt = eg;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input logic [5:0] xv, input logic [5:0] yv);
        x_in[i*WIDTH +: WIDTH] = xv;
        y_in[i*WIDTH +: WIDTH] = yv;
    endtask

    task automatic wait_gnt(input logic [NREQ-1:0] exp, input int bound, output int n);
        n = 0;
        @(negedge clk);
        while (gnt == '0 && n < bound) begin
            @(negedge clk);
            n++;
        end
        chk("gnt_pick", 32'(gnt), 32'(exp));
    endtask

    task automatic wait_valid(input int bound, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!res_valid && n < bound);
        chk("valid_seen", 32'(res_valid), 32'd1);
    endtask

    function automatic logic [5:0] rnd6();
        case ($urandom_range(7))
            0:       return 6'h00;
            1:       return 6'h20;
            2:       return 6'h1F;
            default: return 6'($urandom);
        endcase
    endfunction

    // Directed sequences, then randomized traffic.
    initial begin
        int n;
        rst_n = 1'b0;
        res_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("init_valid", 32'(res_valid), 32'd0);
        chk("init_busy", 32'(busy), 32'd0);
        chk("init_z", 32'(res_z), 32'd0);
        rst_n = 1'b1;

        // Simultaneous req0/req2 right after reset.
        set_op(0, 6'd3, 6'd5);
        set_op(2, 6'h3D, 6'd7);
        req = 4'b0101;
        wait_gnt(4'b0001, 4, n);
        tick(); req = 4'b0100;
        wait_valid(20, n);
        chk("t2_lat", 32'(n), 32'd7);
        chk("t2_z0", 32'(res_z), 32'h00F);
        chk("t2_id0", 32'(res_id), 32'd0);
        wait_gnt(4'b0100, 4, n);
        chk("t2_bubble", 32'(n), 32'd0);
        tick(); req = 4'b0000;
        wait_valid(20, n);
        chk("t2_z2", 32'(res_z), 32'hFEB);
        chk("t2_id2", 32'(res_id), 32'd2);

        // Most-negative operand corners on requester 3.
        tick(); set_op(3, 6'h20, 6'h20); req = 4'b1000;
        wait_gnt(4'b1000, 4, n);
        tick(); req = 4'b0000;
        wait_valid(20, n);
        chk("t4_negneg", 32'(res_z), 32'h400);
        tick(); set_op(3, 6'h20, 6'h1F); req = 4'b1000;
        wait_gnt(4'b1000, 4, n);
        tick(); req = 4'b0000;
        wait_valid(20, n);
        chk("t4_negpos", 32'(res_z), 32'hC20);

        // All four held: order 0,1,2,3,0,1,2,3 at WIDTH+2 spacing.
        tick();
        for (int i = 0; i < NREQ; i++) set_op(i, 6'(i + 1), 6'(i + 2));
        req = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            wait_gnt(4'(1 << (k % 4)), 20, n);
            if (k > 0) chk("t3_gap", 32'(n), 32'd7);
        end
        tick(); req = 4'b0000;
        wait_valid(20, n);

        // Single request: 4 * -2.
        tick(); set_op(0, 6'd4, 6'h3E); req = 4'b0001;
        wait_gnt(4'b0001, 4, n);
        tick(); req = 4'b0000;
        wait_valid(20, n);
        chk("t1_lat", 32'(n), 32'd7);
        chk("t1_z", 32'(res_z), 32'hFF8);
        chk("t1_id", 32'(res_id), 32'd0);

        // Backpressure in DONE with req1 pending.
        tick(); res_ready = 1'b0; set_op(0, 6'd5, 6'h3D); req = 4'b0001;
        wait_gnt(4'b0001, 4, n);
        tick(); set_op(1, 6'd7, 6'd9); req = 4'b0010;
        wait_valid(20, n);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("t5_hold_valid", 32'(res_valid), 32'd1);
            chk("t5_hold_z", 32'(res_z), 32'hFF1);
            chk("t5_hold_id", 32'(res_id), 32'd0);
            chk("t5_no_gnt", 32'(gnt), 32'd0);
        end
        tick(); res_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("t5_gnt1", 32'(gnt), 32'b0010);
        tick(); req = 4'b0000;
        wait_valid(20, n);
        chk("t5_z1", 32'(res_z), 32'h03F);
        chk("t5_id1", 32'(res_id), 32'd1);

        // Reset in mid-RUN aborts the transaction.
        tick(); set_op(3, 6'd3, 6'd3); req = 4'b1000;
        wait_gnt(4'b1000, 4, n);
        tick(); req = 4'b0000;
        tick(); tick();
        rst_n = 1'b0;
        #1;
        chk("t6_busy", 32'(busy), 32'd0);
        chk("t6_z", 32'(res_z), 32'd0);
        chk("t6_id", 32'(res_id), 32'd0);
        tick(); rst_n = 1'b1;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            chk("t6_no_valid", 32'(res_valid), 32'd0);
        end

        // Zero operand.
        tick(); set_op(2, 6'd0, 6'd17); req = 4'b0100;
        wait_gnt(4'b0100, 4, n);
        tick(); req = 4'b0000;
        wait_valid(20, n);
`ifdef BOOTH_ZERO_BYPASS_EN
        chk("zero_lat", 32'(n), 32'd1);
`else
        chk("zero_lat", 32'(n), 32'd7);
`endif
        chk("zero_z", 32'(res_z), 32'd0);

        // Randomized traffic; operands change only while req is low.
        for (int c = 0; c < 600; c++) begin
            tick();
            for (int i = 0; i < NREQ; i++) begin
                if (!req[i]) begin
                    if ($urandom_range(3) == 0) begin
                        set_op(i, rnd6(), rnd6());
                        req[i] = 1'b1;
                    end
                end else if (mdl_gnt[i] && $urandom_range(1) == 0) begin
                    req[i] = 1'b0;
                end
            end
            res_ready = ($urandom_range(3) != 0);
        end
        tick(); req = '0; res_ready = 1'b1;
        repeat (20) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/booth_mult_scheduler.md
Name: booth_mult_scheduler

Overview:
Shares one sequential radix-2 Booth multiply engine among NREQ requesters. Arbitrates round-robin, captures the winner's operands and sequences WIDTH add/subtract-shift iterations. Returns the signed product tagged with the requester id over a valid/ready handshake. Sits between the lab's operand sources and the multiply datapath, replacing the hand-driven load/clk sequencing of the standalone multiplier.

Parameters:
WIDTH, 6, operand width in bits (two's complement); product is 2*WIDTH bits
NREQ, 4, number of requesters (>=2)
IDW, $clog2(NREQ), width of the result id

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
req  in  NREQ  per-requester request; operands must be stable while high
x_in  in  NREQ*WIDTH  multiplicands, requester i at [i*WIDTH +: WIDTH]
y_in  in  NREQ*WIDTH  multipliers, same packing
gnt  out  NREQ  one-hot, one-cycle acceptance pulse
res_valid  out  1  product valid
res_id  out  IDW  index of the requester that owns res_z
res_z  out  2*WIDTH  signed product X*Y
res_ready  in  1  consumer accepts the result
busy  out  1  high in any state except IDLE

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-low (clk, rst_n).
- Reset values: state=IDLE, gnt=0, res_valid=0, res_id=0, res_z=0, busy=0, rr pointer = requester 0 highest priority. Reset mid-operation aborts the transaction; no result is produced.
- FSM IDLE -> RUN -> DONE -> IDLE.
- IDLE:
  - If any req, select the first requester at or after (last_grant+1) mod NREQ.
  - gnt[sel] is driven combinationally high in this cycle.
  - At the edge: capture M=x_in[sel], Q=y_in[sel], A=0, Q-1=0, cnt=WIDTH, id=sel, last_grant=sel; go to RUN.
  - No req: stay in IDLE.
- RUN, one iteration per cycle:
  - {Q0,Q-1}=01: A+=M.
  - {Q0,Q-1}=10: A-=M.
  - 00/11: A unchanged.
  - Then arithmetic right shift of {A,Q,Q-1}; cnt-=1.
  - When cnt reaches 0, go to DONE.
- Width rule: A and M are sign-extended to WIDTH+1 bits so that M=-2^(WIDTH-1) negates without overflow. res_z = {A[WIDTH-1:0],Q}.
- DONE:
  - res_valid=1; res_z and res_id are registered and held stable until res_valid&&res_ready.
  - Then go to IDLE.
  - A new grant requires a pass through IDLE (one bubble cycle, even if req is pending).
- Latency: gnt in cycle T, res_valid first high in cycle T+WIDTH+1. Throughput: one product per WIDTH+2 cycles without backpressure.
- gnt is never asserted outside IDLE. Requests are ignored while busy and are not queued.
- A requester that keeps req high after its gnt is treated as a new request. Round-robin guarantees that waiting requesters are served first.
- res_ready while res_valid=0 is ignored.

Optional Feature:
- Macro BOOTH_ZERO_BYPASS_EN.
- When defined: if the captured x or y is zero at grant, go IDLE -> DONE directly with res_z=0. res_valid rises in cycle T+1.
- When undefined: all operands take the full WIDTH iterations; the result is still 0.

Decomposition:
- Package booth_pkg holds:
  - state enum {IDLE,RUN,DONE}
  - Booth op encoding {NOP,ADD,SUB} derived from {Q0,Q-1}
  - default WIDTH/NREQ localparams
  - a function returning the round-robin next index
- Sub-module booth_step_datapath: holds A/M/Q/Q-1 registers.
  - Inputs: load, step, operands.
  - Outputs: product.
- The scheduler keeps the FSM, counter, arbiter and output registers.

Test Plan:
- Req0 only, x=4, y=-2 -> gnt[0] pulse; res_valid 7 cycles later with res_z=12'hFF8, res_id=0.
- Req0 and req2 simultaneous after reset (x0=3,y0=5; x2=-3,y2=7) -> req0 first (res_z=15), req2 next (res_z=12'hFEB=-21); exactly one bubble between transactions.
- All four req held high for 8 transactions -> grant order 0,1,2,3,0,1,2,3; no gnt while busy.
- x=-32, y=-32 -> res_z=12'h400. x=-32, y=31 -> res_z=12'hC20 (-992).
- res_ready low 5 cycles in DONE with req1 pending -> res_valid/res_z/res_id stable, no gnt; after the handshake, gnt[1] follows in the next cycle.
- rst_n low for 1 cycle in mid-RUN -> all outputs 0 immediately, no res_valid. BOOTH_ZERO_BYPASS_EN defined, x=0, y=17 -> res_valid at T+1 with res_z=0.
